// File: rtl/nibble_compare_sequencer.sv
// nibble_compare_sequencer
// Wide-word magnitude comparator built around an external 4-bit combinational
// comparator. The operand pair is latched on accept and then presented one
// nibble at a time, MSB-first, on nib_a/nib_b. The comparator's gt/lt/eq flags
// are sampled every SCAN cycle. The scan stops on the first unequal nibble, or
// after the last nibble when the words are equal. The verdict is then held
// until the downstream side takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, and out_valid is 1 only in DONE. Neither
// depends combinationally on the other side's valid/ready. In DONE the result
// and scan_cnt hold steady until out_ready is seen.

module nibble_compare_sequencer #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [3:0]       nib_a,
    output logic [3:0]       nib_b,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             cmp_err,
    output logic [IDXW-1:0]  scan_cnt
);

    localparam int NIBS = WIDTH / 4;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [IDXW-1:0]  idx_q,      idx_d;
    logic [IDXW-1:0]  scan_cnt_q, scan_cnt_d;
    logic             gt_q,       gt_d;
    logic             lt_q,       lt_d;
    logic             eq_q,       eq_d;
    logic             err_q,      err_d;

    logic             flags_onehot;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;

    // A sample is legal only when exactly one comparator flag is set.
    always_comb begin
        flags_onehot = 1'b0;
        case ({cmp_gt, cmp_lt, cmp_eq})
            3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
            default:                flags_onehot = 1'b0;
        endcase
    end

    // Select the nibble addressed by the current scan index.
    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int n = 0; n < NIBS; n++) begin
            if (idx_q == IDXW'(n)) begin
                slice_a = a_q[n*4 +: 4];
                slice_b = b_q[n*4 +: 4];
            end
        end
    end

    // Next-state and datapath update for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        scan_cnt_d = scan_cnt_q;
        gt_d       = gt_q;
        lt_d       = lt_q;
        eq_d       = eq_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    idx_d      = LAST_IDX;
                    scan_cnt_d = '0;
                    gt_d       = 1'b0;
                    lt_d       = 1'b0;
                    eq_d       = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                scan_cnt_d = scan_cnt_q + IDXW'(1);
                if (!flags_onehot) begin
                    // A broken comparator gives no trustworthy verdict.
                    err_d   = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (cmp_gt) begin
                    gt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (cmp_lt) begin
                    lt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end

            ST_DONE: begin
                // No same-cycle re-accept: IDLE is always visited for one cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            gt_q       <= gt_d;
            lt_q       <= lt_d;
            eq_q       <= eq_d;
            err_q      <= err_d;
        end
    end

    // Outputs decoded from registered state; nibbles are only driven while scanning.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        nib_a     = 4'h0;
        nib_b     = 4'h0;
        if (state_q == ST_SCAN) begin
            nib_a = slice_a;
            nib_b = slice_b;
        end
        a_gt_b   = gt_q;
        a_lt_b   = lt_q;
        a_eq_b   = eq_q;
        cmp_err  = err_q;
        scan_cnt = scan_cnt_q;
    end

endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// Bench for nibble_compare_sequencer: models the external comparator, runs
// directed transactions, and checks every cycle against a transaction-level model.

module tb_nibble_compare_sequencer;

  localparam int WIDTH = 16;
  localparam int IDXW  = 4;
  localparam int NIBS  = WIDTH / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             err_mode = 1'b0;
  logic             in_ready, out_valid;
  logic [3:0]       nib_a, nib_b;
  logic             cmp_gt, cmp_lt, cmp_eq;
  logic             a_gt_b, a_lt_b, a_eq_b, cmp_err;
  logic [IDXW-1:0]  scan_cnt;

  nibble_compare_sequencer #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .nib_a(nib_a), .nib_b(nib_b),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .cmp_err(cmp_err), .scan_cnt(scan_cnt)
  );

  // External comparator; in err_mode the nibble value 2 produces gt and eq together.
  assign cmp_gt = (err_mode && nib_a == 4'h2) ? 1'b1 : (nib_a > nib_b);
  assign cmp_lt = (err_mode && nib_a == 4'h2) ? 1'b0 : (nib_a < nib_b);
  assign cmp_eq = (err_mode && nib_a == 4'h2) ? 1'b1 : (nib_a == nib_b);

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Verdict from whole-word arithmetic; k = 1-based MSB-first position of the
  // first differing nibble (NIBS if equal), cut short by an injected fault.
  function automatic void model_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input int ep, output int k, output logic gt,
                                     output logic lt, output logic eq, output logic err);
    logic [WIDTH-1:0] d;
    int first;
    d = a ^ b;
    first = NIBS;
    for (int p = NIBS; p >= 1; p--)
      if (((d >> (4 * (NIBS - p))) & 16'hF) != 0) first = p;
    if (ep != 0 && ep <= first) begin
      k = ep; err = 1'b1; gt = 1'b0; lt = 1'b0; eq = 1'b0;
    end else begin
      k = first; err = 1'b0; gt = (a > b); lt = (a < b); eq = (a == b);
    end
  endfunction

  int               m_phase = 0;   // 0 idle, 1 scanning, 2 result offered
  logic [WIDTH-1:0] m_a = '0;
  int               m_k = 0;
  int               m_cnt = 0;
  int               m_err_pos = 0;
  logic             m_gt = 0, m_lt = 0, m_eq = 0, m_err = 0, m_clean = 1;
  logic             p_gt, p_lt, p_eq, p_err;
  logic [WIDTH-1:0] m_b = '0;
  bit               started = 0;

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_clean = 1;
      m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_a = a_in; m_b = b_in;
          model_eval(a_in, b_in, m_err_pos, m_k, p_gt, p_lt, p_eq, p_err);
          m_cnt = 0; m_clean = 0;
          m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
          m_phase = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == m_k) begin
            m_gt = p_gt; m_lt = p_lt; m_eq = p_eq; m_err = p_err;
            m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 1) begin
        chk("nib_a", nib_a, (m_a >> (4 * (NIBS - 1 - m_cnt))) & 16'hF);
        chk("nib_b", nib_b, (m_b >> (4 * (NIBS - 1 - m_cnt))) & 16'hF);
      end else if (m_phase == 0) begin
        chk("nib_a_idle", nib_a, 0);
        chk("nib_b_idle", nib_b, 0);
      end
      if (m_phase == 2 || m_clean) begin
        chk("a_gt_b", a_gt_b, m_gt);
        chk("a_lt_b", a_lt_b, m_lt);
        chk("a_eq_b", a_eq_b, m_eq);
        chk("cmp_err", cmp_err, m_err);
        chk("scan_cnt", scan_cnt, m_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the DUT idle; returns just after the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int ep);
    m_err_pos = ep;
    chk("ready_before_send", in_ready, 1);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = WIDTH'($urandom_range(0, 65535));
    b_in = WIDTH'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_scan_cnt", scan_cnt, 0);
    rst_n = 1'b1;

    // Equal words: full scan.
    send(16'h1234, 16'h1234, 0);
    wait_done(4, "eq");
    chk("eq_flag", a_eq_b, 1);
    chk("eq_scan_cnt", scan_cnt, 4);
    chk("eq_err", cmp_err, 0);
    @(posedge clk); #1;

    // Decided on the first nibble.
    send(16'hA000, 16'h9FFF, 0);
    chk("gt1_nib_a", nib_a, 4'hA);
    chk("gt1_nib_b", nib_b, 4'h9);
    wait_done(1, "gt1");
    chk("gt1_flag", a_gt_b, 1);
    chk("gt1_scan_cnt", scan_cnt, 1);
    @(posedge clk); #1;

    // Decided on the last nibble.
    send(16'h0001, 16'h0002, 0);
    wait_done(4, "lt4");
    chk("lt4_flag", a_lt_b, 1);
    chk("lt4_scan_cnt", scan_cnt, 4);
    @(posedge clk); #1;

    // Back-pressure with a stray in_valid pulse while the result is offered.
    out_ready = 1'b0;
    send(16'h00F0, 16'h0010, 0);
    wait_done(3, "hold");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; a_in = 16'h0000; b_in = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_gt", a_gt_b, 1);
      chk("hold_scan_cnt", scan_cnt, 3);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_ready_back", in_ready, 1);
    chk("hold_valid_drop", out_valid, 0);

    // Illegal comparator flags on the second nibble.
    err_mode = 1'b1;
    send(16'h1234, 16'h1234, 2);
    wait_done(2, "err");
    chk("err_flag", cmp_err, 1);
    chk("err_results", {a_gt_b, a_lt_b, a_eq_b}, 3'b000);
    chk("err_scan_cnt", scan_cnt, 2);
    @(posedge clk); #1;
    err_mode = 1'b0;

    // Reset in the middle of a scan, then a fresh transaction.
    send(16'h1111, 16'h1111, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_results", {a_gt_b, a_lt_b, a_eq_b, cmp_err}, 4'b0000);
    chk("rst_scan_cnt", scan_cnt, 0);
    chk("rst_nibs", {nib_a, nib_b}, 8'h00);
    send(16'h0005, 16'h0003, 0);
    wait_done(4, "post_rst");
    chk("post_rst_gt", a_gt_b, 1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_compare_sequencer.md
Name: nibble_compare_sequencer

Overview:
- Sequential wide-word magnitude comparator that sits directly upstream of the team's 4-bit combinational comparator and also consumes its result.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and presents 4-bit slices MSB-first on nib_a/nib_b.
- Samples the comparator's gt/lt/eq flags each cycle, terminates early on the first unequal slice, and returns the final verdict over a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. NIBS = WIDTH/4.
- IDXW, 4, width of the slice index and scan counter; must satisfy 2^IDXW > NIBS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- nib_a  output  4  current slice of A, to the external comparator.
- nib_b  output  4  current slice of B, to the external comparator.
- cmp_gt  input  1  comparator flag, combinational from nib_a/nib_b.
- cmp_lt  input  1  comparator flag.
- cmp_eq  input  1  comparator flag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- a_gt_b  output  1  final result: A > B.
- a_lt_b  output  1  final result: A < B.
- a_eq_b  output  1  final result: A == B.
- cmp_err  output  1  an illegal flag combination was sampled.
- scan_cnt  output  IDXW  number of slices examined for the current result.

Behaviour:
- Reset is synchronous to clk and active-low (rst_n). It applies in any state and takes effect at the next edge, aborting any scan.
- Reset values: state IDLE, in_ready=1, out_valid=0, a_gt_b=a_lt_b=a_eq_b=0, cmp_err=0, scan_cnt=0, nib_a=nib_b=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: register a_in/b_in, set idx=NIBS-1, scan_cnt=0, clear result flags and cmp_err, go to SCAN.
  - nib_a/nib_b are driven to 0.
- SCAN:
  - in_ready=0.
  - nib_a = a_reg[idx*4+3 : idx*4] and nib_b = b_reg[idx*4+3 : idx*4], both combinational from registers.
  - Each edge: scan_cnt increments.
  - Flag decode, applied in this priority order at each edge:
    - Flags not one-hot: cmp_err=1, all result flags 0, go to DONE.
    - cmp_gt: a_gt_b=1, go to DONE.
    - cmp_lt: a_lt_b=1, go to DONE.
    - cmp_eq with idx==0: a_eq_b=1, go to DONE.
    - cmp_eq otherwise: idx decrements, stay in SCAN.
- DONE:
  - out_valid=1, in_ready=0.
  - Results and scan_cnt are held stable while out_valid=1 and out_ready=0.
  - When out_ready=1 at an edge: out_valid drops and the block returns to IDLE. in_ready is 1 in the following cycle; there is no same-cycle accept of new input.
- Latency: from the accept edge to out_valid high is k cycles, where k is the 1-based position (counted MSB-first) of the first unequal slice, or NIBS if A == B. Minimum 1 cycle, maximum NIBS cycles.
- Throughput: one result per k+2 cycles when out_ready is held at 1.
- Result flags are mutually exclusive. They are all 0 only when cmp_err=1.
- The comparator is purely combinational with zero-cycle latency. No registering of the flags occurs before they are sampled.
- in_valid while busy is ignored. The operands are not sampled.
- Operand registers are written only on an accept edge, so changes on a_in/b_in mid-scan have no effect.

Test Plan:
- WIDTH=16, a=0x1234, b=0x1234, out_ready=1, bench models comparator -> out_valid 4 cycles after accept, a_eq_b=1, scan_cnt=4, cmp_err=0.
- a=0xA000, b=0x9FFF -> nib_a=0xA, nib_b=0x9 in the first SCAN cycle; a_gt_b=1 after 1 cycle, scan_cnt=1.
- a=0x0001, b=0x0002 -> nibble sequence 0,0,0,1 vs 0,0,0,2; a_lt_b=1 after 4 cycles, scan_cnt=4.
- a=0x00F0, b=0x0010 with out_ready=0 for 5 cycles, and a new in_valid pulse during DONE -> a_gt_b=1, scan_cnt=3 held for 5 cycles. The extra input is ignored. in_ready returns to 1 one cycle after out_ready=1.
- Comparator model forced to drive gt=1 and eq=1 on the second slice -> cmp_err=1, all result flags 0, scan_cnt=2.
- rst_n=0 for one edge during SCAN of a=0x1111, b=0x1111 -> next cycle state IDLE, in_ready=1, out_valid=0, all outputs at their reset values. A fresh a=0x0005, b=0x0003 afterwards yields a_gt_b=1.
